// File: rtl/lvdc_io_ctrl.sv
// lvdc_io_ctrl: LVDC bus I/O controller with output latches, input ports, interrupts and SPI flash master.
// The SPI engine is built only when LVDC_IO_SPI_EN is defined.
module lvdc_io_ctrl #(
    parameter int DATA_W  = 26,
    parameter int NUM_OUT = 2,
    parameter int OUT_W   = 8,
    parameter int NUM_IN  = 2,
    parameter int IN_W    = 8,
    parameter int NUM_IRQ = 4,
    parameter int SPI_DIV = 2
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     nIOR,
    input  logic                     nIOW,
    input  logic [3:0]               I,
    input  logic [DATA_W-1:0]        db_in,
    output logic [DATA_W-1:0]        db_out,
    output logic                     db_oe,
    output logic [NUM_OUT*OUT_W-1:0] gpio_out,
    input  logic [NUM_IN*IN_W-1:0]   gpio_in,
    input  logic [NUM_IRQ-1:0]       irq,
    output logic                     int_out,
    output logic                     flash_csb,
    output logic                     sck,
    output logic                     sdo,
    input  logic                     sdi
);
    localparam int GW = NUM_IN * IN_W;
    localparam int SW = GW + NUM_IRQ + 2;
    // Strobes idle high so leaving reset never looks like a bus cycle
    localparam logic [SW-1:0] SYNC_RST = {2'b11, {(SW - 2){1'b0}}};

    logic [SW-1:0] s1_q, s1_d, s2_q, s2_d;
    logic nior_p_q, nior_p_d, niow_p_q, niow_p_d;
    logic [NUM_IRQ-1:0] irq_p_q, irq_p_d, pend_q, pend_d, mask_q, mask_d;
    logic [NUM_OUT*OUT_W-1:0] out_q, out_d;
    logic cs_q, cs_d, inh_q, inh_d, ovr_q, ovr_d, int_q, int_d, oe_q, oe_d;
    logic [DATA_W-1:0] dout_q, dout_d, rd;
    logic nior_s, niow_s, wr, rd_fall, rd_rise, busy, ovr_set;
    logic [NUM_IRQ-1:0] irq_s;
    logic [GW-1:0] gin_s;
    logic [7:0] spi_rd;
    logic unused_ok;

    assign {nior_s, niow_s, irq_s, gin_s} = s2_q;
    assign wr = !niow_s && niow_p_q;
    assign rd_fall = !nior_s && nior_p_q && !wr;
    assign rd_rise = nior_s && !nior_p_q;
    assign unused_ok = ^{db_in, sdi};

    always_comb begin
        s1_d = {nIOR, nIOW, irq, gpio_in};
        s2_d = s1_q;
        nior_p_d = nior_s;
        niow_p_d = niow_s;
        irq_p_d = irq_s;
        out_d = out_q;
        mask_d = mask_q;
        cs_d = cs_q;
        inh_d = inh_q;
        ovr_d = ovr_q | ovr_set;
        pend_d = pend_q;
        if (wr) begin
            for (int n = 0; n < NUM_OUT; n++)
                if (I == 4'(n)) out_d[n*OUT_W +: OUT_W] = db_in[OUT_W-1:0];
            if (I == 4'h8) pend_d = pend_q & ~db_in[NUM_IRQ-1:0];
            if (I == 4'h9) mask_d = db_in[NUM_IRQ-1:0];
            if (I == 4'hB) begin
                cs_d = db_in[0];
                inh_d = db_in[1];
                ovr_d = ovr_q & ~db_in[3];
            end
        end
        // New edges applied after the clear so a coincident request is never lost
        pend_d = pend_d | (irq_s & ~irq_p_q);
        int_d = (|(pend_q & mask_q)) & ~inh_q;
        rd = '0;
        for (int n = 0; n < NUM_OUT; n++)
            if (I == 4'(n)) rd[OUT_W-1:0] = out_q[n*OUT_W +: OUT_W];
        for (int n = 0; n < NUM_IN; n++)
            if (I == 4'(4 + n)) rd[IN_W-1:0] = gin_s[n*IN_W +: IN_W];
        if (I == 4'h8) rd[NUM_IRQ-1:0] = pend_q;
        if (I == 4'h9) rd[NUM_IRQ-1:0] = mask_q;
        if (I == 4'hA) rd[7:0] = spi_rd;
        if (I == 4'hB) rd[3:0] = {ovr_q, busy, inh_q, cs_q};
        dout_d = rd_fall ? rd : (rd_rise ? '0 : dout_q);
        oe_d = rd_fall | (oe_q & ~rd_rise);
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            s1_q <= SYNC_RST;
            s2_q <= SYNC_RST;
            nior_p_q <= 1'b1;
            niow_p_q <= 1'b1;
            irq_p_q <= '0;
            out_q <= '0;
            mask_q <= '0;
            pend_q <= '0;
            cs_q <= 1'b0;
            inh_q <= 1'b0;
            ovr_q <= 1'b0;
            int_q <= 1'b0;
            oe_q <= 1'b0;
            dout_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            nior_p_q <= nior_p_d;
            niow_p_q <= niow_p_d;
            irq_p_q <= irq_p_d;
            out_q <= out_d;
            mask_q <= mask_d;
            pend_q <= pend_d;
            cs_q <= cs_d;
            inh_q <= inh_d;
            ovr_q <= ovr_d;
            int_q <= int_d;
            oe_q <= oe_d;
            dout_q <= dout_d;
        end
    end

    assign gpio_out = out_q;
    assign db_out = dout_q;
    assign db_oe = oe_q;
    assign int_out = int_q;
    assign flash_csb = ~cs_q;

`ifdef LVDC_IO_SPI_EN
    localparam int CW = $clog2(SPI_DIV + 1);
    typedef enum logic {IDLE, SHIFT} spi_st_e;
    spi_st_e st_q, st_d;
    logic sck_q, sck_d, spi_wr;
    logic [2:0] bit_q, bit_d;
    logic [CW-1:0] div_q, div_d;
    logic [7:0] tx_q, tx_d, rx_q, rx_d, rbyte_q, rbyte_d;

    assign spi_wr = wr && I == 4'hA;
    assign busy = st_q == SHIFT;
    assign ovr_set = spi_wr && busy;
    assign spi_rd = rbyte_q;
    assign sck = sck_q;
    assign sdo = tx_q[7];

    always_comb begin
        st_d = st_q;
        sck_d = sck_q;
        bit_d = bit_q;
        div_d = div_q;
        tx_d = tx_q;
        rx_d = rx_q;
        rbyte_d = rbyte_q;
        if (st_q == IDLE) begin
            if (spi_wr) begin
                st_d = SHIFT;
                tx_d = db_in[7:0];
                bit_d = '0;
                div_d = '0;
            end
        end else begin
            div_d = div_q + CW'(1);
            if (div_q == CW'(SPI_DIV - 1)) begin
                div_d = '0;
                sck_d = ~sck_q;
                if (!sck_q) rx_d = {rx_q[6:0], sdi};
                else if (bit_q == 3'd7) begin
                    st_d = IDLE;
                    sck_d = 1'b0;
                    rbyte_d = rx_q;
                end else begin
                    tx_d = {tx_q[6:0], 1'b0};
                    bit_d = bit_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            st_q <= IDLE;
            sck_q <= 1'b0;
            bit_q <= '0;
            div_q <= '0;
            tx_q <= '0;
            rx_q <= '0;
            rbyte_q <= '0;
        end else begin
            st_q <= st_d;
            sck_q <= sck_d;
            bit_q <= bit_d;
            div_q <= div_d;
            tx_q <= tx_d;
            rx_q <= rx_d;
            rbyte_q <= rbyte_d;
        end
    end
`else
    assign busy = 1'b0;
    assign ovr_set = 1'b0;
    assign spi_rd = '0;
    assign sck = 1'b0;
    assign sdo = 1'b0;
`endif
endmodule

// File: tb/tb_lvdc_io_ctrl.sv
// tb_lvdc_io_ctrl: scoreboard bench for lvdc_io_ctrl against a register-level reference model.
module tb_lvdc_io_ctrl;
    logic clk = 0, rstb = 0, nIOR = 1, nIOW = 1, sdi = 0;
    logic [3:0] I = 0;
    logic [25:0] db_in = 0;
    logic [25:0] db_out;
    logic db_oe, int_out, flash_csb, sck, sdo;
    logic [15:0] gpio_out;
    logic [15:0] gpio_in = 0;
    logic [3:0] irq = 0;

    always #5 clk = ~clk;

    lvdc_io_ctrl dut (
        .clk(clk), .rstb(rstb), .nIOR(nIOR), .nIOW(nIOW), .I(I),
        .db_in(db_in), .db_out(db_out), .db_oe(db_oe),
        .gpio_out(gpio_out), .gpio_in(gpio_in), .irq(irq), .int_out(int_out),
        .flash_csb(flash_csb), .sck(sck), .sdo(sdo), .sdi(sdi)
    );

    int n_chk = 0, n_pass = 0, slave_k = 0;
    logic [29:0] exp_q[$];
    logic oe_prev = 0;
    logic [7:0] m_out[2];
    logic [7:0] m_gin[2];
    logic [3:0] m_pend, m_mask, ra, rb;
    logic m_cs, m_inh, m_ovr, m_busy;
    logic [7:0] m_rx, cap, slave_pat;
    time t_wr, t_spi, t_done;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic mreset();
        m_out[0] = 0; m_out[1] = 0;
        m_pend = 0; m_mask = 0; m_cs = 0; m_inh = 0; m_ovr = 0; m_busy = 0; m_rx = 0;
    endtask

    function automatic logic m_int();
        return (|(m_pend & m_mask)) && !m_inh;
    endfunction

    function automatic logic [25:0] mread(input logic [3:0] a);
        logic [25:0] r = '0;
        if (a < 2) r[7:0] = m_out[a[0]];
        else if (a >= 4 && a < 6) r[7:0] = m_gin[a[0]];
        else if (a == 8) r[3:0] = m_pend;
        else if (a == 9) r[3:0] = m_mask;
`ifdef LVDC_IO_SPI_EN
        else if (a == 10) r[7:0] = m_rx;
`endif
        else if (a == 11) r[3:0] = {m_ovr, m_busy, m_inh, m_cs};
        return r;
    endfunction

    task automatic io_write(input logic [3:0] a, input logic [25:0] d, input logic [3:0] ip);
        logic [15:0] g_old;
        g_old = {m_out[1], m_out[0]};
        @(negedge clk);
        I = a; db_in = d; nIOW = 0; irq = irq | ip; t_wr = $time;
        if (a < 2) m_out[a[0]] = d[7:0];
        if (a == 8) m_pend = m_pend & ~d[3:0];
        if (a == 9) m_mask = d[3:0];
        if (a == 11) begin
            m_cs = d[0]; m_inh = d[1];
            if (d[3]) m_ovr = 0;
        end
`ifdef LVDC_IO_SPI_EN
        if (a == 10) begin
            if (m_busy) m_ovr = 1;
            else m_busy = 1;
        end
`endif
        m_pend = m_pend | ip;
        repeat (2) @(negedge clk);
        check("wr_early", gpio_out, g_old);
        @(negedge clk);
        check("wr_commit", gpio_out, {m_out[1], m_out[0]});
        repeat (2) @(negedge clk);
        nIOW = 1; irq = irq & ~ip;
        repeat (5) @(negedge clk);
        check("int_after_wr", int_out, m_int());
    endtask

    task automatic io_read(input logic [3:0] a);
        @(negedge clk);
        I = a; nIOR = 0;
        exp_q.push_back({a, mread(a)});
        repeat (4) @(negedge clk);
        check("oe_during", db_oe, 1);
        nIOR = 1;
        repeat (2) @(negedge clk);
        check("oe_hold", db_oe, 1);
        @(negedge clk);
        check("oe_release", {db_oe, db_out}, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic irq_pulse(input logic [3:0] b);
        logic o;
        o = m_int();
        @(negedge clk);
        irq = b; m_pend = m_pend | b;
        repeat (3) @(negedge clk);
        check("int_before", int_out, o);
        @(negedge clk);
        check("int_set", int_out, m_int());
        irq = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic sb_pop();
        logic [29:0] e;
        if (exp_q.size() == 0) check("sb_unexpected_read", 1, 0);
        else begin
            e = exp_q.pop_front();
            check($sformatf("rd@%0h", e[29:26]), db_out, e[25:0]);
        end
    endtask

    always @(negedge clk) begin
        if (db_oe && !oe_prev) sb_pop();
        oe_prev <= db_oe;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        mreset();
        m_gin[0] = 0; m_gin[1] = 0;
        slave_pat = 8'hEF;
        repeat (3) @(negedge clk);
        check("rst_gpio", gpio_out, 0);
        check("rst_bus", {db_oe, db_out}, 0);
        check("rst_int", int_out, 0);
        check("rst_spi_pins", {flash_csb, sck, sdo}, 3'b100);
        rstb = 1;
        repeat (3) @(negedge clk);

        io_write(4'h1, 26'h0A5, 4'h0);
        check("out1_a5", gpio_out, 16'hA500);
        io_read(4'h1);

        m_gin[0] = 8'h3C; m_gin[1] = 8'h81;
        gpio_in = {m_gin[1], m_gin[0]};
        repeat (3) @(negedge clk);
        io_read(4'h4);
        io_read(4'h5);
        io_read(4'h7);

        io_write(4'h9, 26'h5, 4'h0);
        irq_pulse(4'b0011);
        io_read(4'h8);
        io_write(4'hB, 26'h2, 4'h0);
        check("inhibit", int_out, 0);
        io_write(4'h8, 26'h1, 4'b0001);
        io_read(4'h8);
        io_write(4'h8, 26'h3, 4'h0);
        io_read(4'h8);
        io_write(4'hB, 26'h0, 4'h0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(3))
                0: begin
                    ra = 4'($urandom_range(15));
                    if (ra == 4'hA) ra = 4'hB;
                    io_write(ra, 26'($urandom), 4'h0);
                end
                1: begin
                    ra = 4'($urandom_range(15));
                    if (ra == 4'hA) ra = 4'h9;
                    io_read(ra);
                end
                2: begin
                    m_gin[0] = 8'($urandom); m_gin[1] = 8'($urandom);
                    gpio_in = {m_gin[1], m_gin[0]};
                    repeat (3) @(negedge clk);
                end
                default: begin
                    rb = 4'($urandom_range(15));
                    irq_pulse(rb);
                end
            endcase
        end

`ifdef LVDC_IO_SPI_EN
        io_write(4'hB, 26'h1, 4'h0);
        check("csb_low", flash_csb, 0);
        cap = 0;
        fork
            begin
                for (int b = 7; b >= 0; b--) begin
                    sdi = slave_pat[b];
                    slave_k = 0;
                    while (sck !== 1'b1 && slave_k < 20) begin @(negedge clk); slave_k++; end
                    cap = {cap[6:0], sdo};
                    slave_k = 0;
                    while (sck !== 1'b0 && slave_k < 20) begin @(negedge clk); slave_k++; end
                end
                t_done = $time;
            end
            begin
                io_write(4'hA, 26'h09F, 4'h0);
                t_spi = t_wr;
                io_write(4'hA, 26'h055, 4'h0);
                io_read(4'hB);
            end
        join
        check("spi_sdo_bits", cap, 8'h9F);
        check("spi_busy_clks", 32'((t_done - t_spi - 30) / 10), 32);
        m_busy = 0; m_rx = 8'hEF;
        io_read(4'hA);
        io_read(4'hB);
        io_write(4'hB, 26'h9, 4'h0);
        io_read(4'hB);

        io_write(4'hA, 26'h0C3, 4'h0);
        slave_k = 0;
        while (sck !== 1'b1 && slave_k < 40) begin @(negedge clk); slave_k++; end
        check("sck_high_pre_rst", sck, 1);
        rstb = 0;
        @(negedge clk);
        check("rst_abort_pins", {sck, flash_csb, sdo}, 3'b010);
        rstb = 1;
        mreset();
        repeat (3) @(negedge clk);
        io_read(4'hB);
`else
        io_write(4'hA, 26'h09F, 4'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_spi_pins", {sck, sdo}, 0);
        end
        io_read(4'hA);
        io_write(4'hB, 26'hB, 4'h0);
        check("csb_low", flash_csb, 0);
        io_read(4'hB);
        io_write(4'hB, 26'h0, 4'h0);
        check("csb_high", flash_csb, 1);
`endif
        repeat (5) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
